// File: rtl/nor_cmd_seq.sv
// ---------------------------------------------------------------------------
// nor_cmd_seq
//   Runs JEDEC NOR command scripts (word program, sector erase, chip erase,
//   read-reset) as a pipelined wishbone master in front of nor_bus. One host
//   command is taken at a time. Its unlock/command writes are issued in
//   order. Program and erase commands then data-poll the target address on
//   DQ7/DQ5 until the operation completes, fails, or the poll budget is used
//   up. Completion is reported to the host as a one-cycle done pulse with an
//   error flag.
//
// Ports
//   wb_clk_i, wb_rst_ni            clock, asynchronous active-low reset
//   cmd_valid_i / cmd_ready_o      host command handshake (ready only in IDLE)
//   cmd_op_i                       0=PROGRAM 1=SECTOR_ERASE 2=CHIP_ERASE 3=READ_RESET
//   cmd_adr_i, cmd_dat_i           word/sector address, program data
//   done_o, err_o, busy_o          completion pulse, error (valid with done), busy
//   wbm_cyc_o .. wbm_dat_o         wishbone master request side
//   wbm_dat_i, wbm_ack_i,
//   wbm_stall_i                    wishbone master response side
// ---------------------------------------------------------------------------
module nor_cmd_seq #(
    parameter int unsigned ADDRBITS    = 26,
    parameter int unsigned DATABITS    = 16,
    parameter int unsigned POLLBITS    = 20,
    parameter int unsigned UNLOCK1_ADR = 32'h0000_0555,
    parameter int unsigned UNLOCK2_ADR = 32'h0000_02AA
) (
    input  logic                wb_clk_i,
    input  logic                wb_rst_ni,
    input  logic                cmd_valid_i,
    output logic                cmd_ready_o,
    input  logic [1:0]          cmd_op_i,
    input  logic [ADDRBITS-1:0] cmd_adr_i,
    input  logic [DATABITS-1:0] cmd_dat_i,
    output logic                done_o,
    output logic                err_o,
    output logic                busy_o,
    output logic                wbm_cyc_o,
    output logic                wbm_stb_o,
    output logic                wbm_we_o,
    output logic [ADDRBITS-1:0] wbm_adr_o,
    output logic [DATABITS-1:0] wbm_dat_o,
    input  logic [DATABITS-1:0] wbm_dat_i,
    input  logic                wbm_ack_i,
    input  logic                wbm_stall_i
);

    localparam logic [1:0] OP_PROGRAM    = 2'd0;
    localparam logic [1:0] OP_SECTOR     = 2'd1;
    localparam logic [1:0] OP_CHIP       = 2'd2;
    localparam logic [1:0] OP_READ_RESET = 2'd3;

    localparam logic [ADDRBITS-1:0] U1_ADR   = ADDRBITS'(UNLOCK1_ADR);
    localparam logic [ADDRBITS-1:0] U2_ADR   = ADDRBITS'(UNLOCK2_ADR);
    localparam logic [POLLBITS-1:0] POLL_MAX = {POLLBITS{1'b1}};

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_WR       = 3'd1,
        S_POLL_RD  = 3'd2,
        S_POLL_CHK = 3'd3,
        S_RE_RD    = 3'd4,
        S_RST_CMD  = 3'd5,
        S_DONE     = 3'd6
    } state_t;

    // Script constants are 8-bit and zero-extended onto the data bus.
    function automatic logic [DATABITS-1:0] f_ext8(input logic [7:0] b);
        return DATABITS'(b);
    endfunction

    // Address of write step 'step' of the script for 'op'.
    function automatic logic [ADDRBITS-1:0] f_step_adr(
        input logic [1:0]          op,
        input logic [2:0]          step,
        input logic [ADDRBITS-1:0] adr
    );
        logic [ADDRBITS-1:0] a;
        a = adr;
        case (op)
            OP_PROGRAM: begin
                case (step)
                    3'd0, 3'd2: a = U1_ADR;
                    3'd1:       a = U2_ADR;
                    default:    a = adr;
                endcase
            end
            OP_SECTOR: begin
                case (step)
                    3'd0, 3'd2, 3'd3: a = U1_ADR;
                    3'd1, 3'd4:       a = U2_ADR;
                    default:          a = adr;
                endcase
            end
            OP_CHIP: begin
                case (step)
                    3'd1, 3'd4: a = U2_ADR;
                    default:    a = U1_ADR;
                endcase
            end
            default: a = adr;
        endcase
        return a;
    endfunction

    // Data of write step 'step' of the script for 'op'.
    function automatic logic [DATABITS-1:0] f_step_dat(
        input logic [1:0]          op,
        input logic [2:0]          step,
        input logic [DATABITS-1:0] dat
    );
        logic [DATABITS-1:0] d;
        d = f_ext8(8'hF0);
        case (op)
            OP_PROGRAM: begin
                case (step)
                    3'd0:    d = f_ext8(8'hAA);
                    3'd1:    d = f_ext8(8'h55);
                    3'd2:    d = f_ext8(8'hA0);
                    default: d = dat;
                endcase
            end
            OP_SECTOR, OP_CHIP: begin
                case (step)
                    3'd0, 3'd3: d = f_ext8(8'hAA);
                    3'd1, 3'd4: d = f_ext8(8'h55);
                    3'd2:       d = f_ext8(8'h80);
                    default:    d = (op == OP_CHIP) ? f_ext8(8'h10) : f_ext8(8'h30);
                endcase
            end
            default: d = f_ext8(8'hF0);
        endcase
        return d;
    endfunction

    // Index of the final write step of each script.
    function automatic logic [2:0] f_last_step(input logic [1:0] op);
        logic [2:0] s;
        case (op)
            OP_PROGRAM:        s = 3'd3;
            OP_SECTOR, OP_CHIP: s = 3'd5;
            default:           s = 3'd0;
        endcase
        return s;
    endfunction

    state_t              r_state;
    logic [1:0]          r_op;
    logic [ADDRBITS-1:0] r_adr;
    logic [DATABITS-1:0] r_dat;
    logic [2:0]          r_step;
    logic [POLLBITS-1:0] r_poll_cnt;
    logic                r_rd_dq7;
    logic                r_rd_dq5;
    logic                r_err;
    logic                r_outst;
    logic                r_ready;
    logic                r_done;
    logic                r_err_o;
    logic                r_busy;
    logic                r_cyc;
    logic                r_stb;
    logic                r_we;
    logic [ADDRBITS-1:0] r_wb_adr;
    logic [DATABITS-1:0] r_wb_dat;

    logic                w_accept;
    logic                w_ack;
    logic                w_expect_dq7;
    logic                w_last;
    logic [2:0]          w_next_step;
    logic [ADDRBITS-1:0] w_next_adr;
    logic [DATABITS-1:0] w_next_dat;
    logic [ADDRBITS-1:0] w_first_adr;
    logic [DATABITS-1:0] w_first_dat;

    // Bus handshake qualifiers, poll expectation and next script step.
    always_comb begin
        w_accept     = r_stb & ~wbm_stall_i;
        // An ack only counts against a request the slave has actually taken.
        w_ack        = wbm_ack_i & (r_outst | w_accept);
        if (r_op == OP_PROGRAM) begin
            w_expect_dq7 = r_dat[7];
        end else begin
            w_expect_dq7 = 1'b1;
        end
        w_last       = (r_step == f_last_step(r_op));
        w_next_step  = r_step + 3'd1;
        w_next_adr   = f_step_adr(r_op, w_next_step, r_adr);
        w_next_dat   = f_step_dat(r_op, w_next_step, r_dat);
        w_first_adr  = f_step_adr(cmd_op_i, 3'd0, cmd_adr_i);
        w_first_dat  = f_step_dat(cmd_op_i, 3'd0, cmd_dat_i);
    end

    // Command sequencer FSM with registered host and wishbone outputs.
    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            r_state    <= S_IDLE;
            r_op       <= 2'd0;
            r_adr      <= '0;
            r_dat      <= '0;
            r_step     <= 3'd0;
            r_poll_cnt <= '0;
            r_rd_dq7   <= 1'b0;
            r_rd_dq5   <= 1'b0;
            r_err      <= 1'b0;
            r_outst    <= 1'b0;
            r_ready    <= 1'b1;
            r_done     <= 1'b0;
            r_err_o    <= 1'b0;
            r_busy     <= 1'b0;
            r_cyc      <= 1'b0;
            r_stb      <= 1'b0;
            r_we       <= 1'b0;
            r_wb_adr   <= '0;
            r_wb_dat   <= '0;
        end else begin
            r_done  <= 1'b0;
            r_err_o <= 1'b0;

            // Request leaves the bus once taken; later assignments below
            // may re-raise stb for the following transaction.
            if (w_accept) begin
                r_stb   <= 1'b0;
                r_outst <= 1'b1;
            end
            if (w_ack) begin
                r_outst <= 1'b0;
            end

            case (r_state)
                S_IDLE: begin
                    if (cmd_valid_i) begin
                        r_op       <= cmd_op_i;
                        r_adr      <= cmd_adr_i;
                        r_dat      <= cmd_dat_i;
                        r_step     <= 3'd0;
                        r_poll_cnt <= '0;
                        r_err      <= 1'b0;
                        r_ready    <= 1'b0;
                        r_busy     <= 1'b1;
                        r_cyc      <= 1'b1;
                        r_stb      <= 1'b1;
                        r_we       <= 1'b1;
                        r_wb_adr   <= w_first_adr;
                        r_wb_dat   <= w_first_dat;
                        r_state    <= S_WR;
                    end
                end

                S_WR: begin
                    if (w_ack) begin
                        if (w_last) begin
                            if (r_op == OP_READ_RESET) begin
                                r_done  <= 1'b1;
                                r_err_o <= 1'b0;
                                r_cyc   <= 1'b0;
                                r_stb   <= 1'b0;
                                r_state <= S_DONE;
                            end else begin
                                r_stb    <= 1'b1;
                                r_we     <= 1'b0;
                                r_wb_adr <= r_adr;
                                r_wb_dat <= '0;
                                r_state  <= S_POLL_RD;
                            end
                        end else begin
                            r_step   <= w_next_step;
                            r_stb    <= 1'b1;
                            r_we     <= 1'b1;
                            r_wb_adr <= w_next_adr;
                            r_wb_dat <= w_next_dat;
                        end
                    end
                end

                S_POLL_RD: begin
                    if (w_ack) begin
                        r_rd_dq7 <= wbm_dat_i[7];
                        r_rd_dq5 <= wbm_dat_i[5];
                        // Counts completed poll reads; holds at the maximum.
                        if (r_poll_cnt != POLL_MAX) begin
                            r_poll_cnt <= r_poll_cnt + {{(POLLBITS-1){1'b0}}, 1'b1};
                        end
                        r_state <= S_POLL_CHK;
                    end
                end

                S_POLL_CHK: begin
                    if (r_rd_dq7 == w_expect_dq7) begin
                        r_done  <= 1'b1;
                        r_err_o <= 1'b0;
                        r_cyc   <= 1'b0;
                        r_stb   <= 1'b0;
                        r_state <= S_DONE;
                    end else if (r_rd_dq5) begin
                        // DQ5 set: DQ7 may have flipped together with it, so
                        // re-read once before declaring failure.
                        r_stb    <= 1'b1;
                        r_we     <= 1'b0;
                        r_wb_adr <= r_adr;
                        r_wb_dat <= '0;
                        r_state  <= S_RE_RD;
                    end else if (r_poll_cnt == POLL_MAX) begin
                        r_err    <= 1'b1;
                        r_stb    <= 1'b1;
                        r_we     <= 1'b1;
                        r_wb_adr <= r_adr;
                        r_wb_dat <= f_ext8(8'hF0);
                        r_state  <= S_RST_CMD;
                    end else begin
                        r_stb    <= 1'b1;
                        r_we     <= 1'b0;
                        r_wb_adr <= r_adr;
                        r_wb_dat <= '0;
                        r_state  <= S_POLL_RD;
                    end
                end

                S_RE_RD: begin
                    if (w_ack) begin
                        if (wbm_dat_i[7] == w_expect_dq7) begin
                            r_done  <= 1'b1;
                            r_err_o <= 1'b0;
                            r_cyc   <= 1'b0;
                            r_stb   <= 1'b0;
                            r_state <= S_DONE;
                        end else begin
                            r_err    <= 1'b1;
                            r_stb    <= 1'b1;
                            r_we     <= 1'b1;
                            r_wb_adr <= r_adr;
                            r_wb_dat <= f_ext8(8'hF0);
                            r_state  <= S_RST_CMD;
                        end
                    end
                end

                S_RST_CMD: begin
                    if (w_ack) begin
                        r_done  <= 1'b1;
                        r_err_o <= r_err;
                        r_cyc   <= 1'b0;
                        r_stb   <= 1'b0;
                        r_state <= S_DONE;
                    end
                end

                S_DONE: begin
                    r_busy  <= 1'b0;
                    r_ready <= 1'b1;
                    r_we    <= 1'b0;
                    r_state <= S_IDLE;
                end

                default: begin
                    r_ready <= 1'b1;
                    r_busy  <= 1'b0;
                    r_cyc   <= 1'b0;
                    r_stb   <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign cmd_ready_o = r_ready;
    assign done_o      = r_done;
    assign err_o       = r_err_o;
    assign busy_o      = r_busy;
    assign wbm_cyc_o   = r_cyc;
    assign wbm_stb_o   = r_stb;
    assign wbm_we_o    = r_we;
    assign wbm_adr_o   = r_wb_adr;
    assign wbm_dat_o   = r_wb_dat;

endmodule
